// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM layer controllers.
//   - Default parameter values for the tile scheduler and base generator.
//   - Scheduler state encoding.
package gemm_pkg;

    localparam int TILE_W_DEF      = 8;
    localparam int MEM0_AW_DEF     = 13;
    localparam int MEM1_AW_DEF     = 11;
    localparam int MEM2_AW_DEF     = 10;
    localparam int DRAIN_CYC_DEF   = 4;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/gemm_base_gen.sv
// Three BRAM base-address accumulators (ifmap / weight / ofmap).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clear                zero all three bases
//   load                 capture the three stride inputs
//   step                 advance every base by its captured stride
//   stride0..2           per-tile stride inputs
//   base0..2             registered base outputs
// Bases wrap modulo 2^width; clear has priority over step.
module gemm_base_gen
    import gemm_pkg::*;
#(
    parameter int A0_W = MEM0_AW_DEF,
    parameter int A1_W = MEM1_AW_DEF,
    parameter int A2_W = MEM2_AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            step,
    input  logic [A0_W-1:0] stride0,
    input  logic [A1_W-1:0] stride1,
    input  logic [A2_W-1:0] stride2,
    output logic [A0_W-1:0] base0,
    output logic [A1_W-1:0] base1,
    output logic [A2_W-1:0] base2
);

    logic [A0_W-1:0] stride0_q;
    logic [A1_W-1:0] stride1_q;
    logic [A2_W-1:0] stride2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride0_q <= '0;
            stride1_q <= '0;
            stride2_q <= '0;
        end else if (load) begin
            stride0_q <= stride0;
            stride1_q <= stride1;
            stride2_q <= stride2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            base0 <= '0;
            base1 <= '0;
            base2 <= '0;
        end else if (step) begin
            base0 <= base0 + stride0_q;
            base1 <= base1 + stride1_q;
            base2 <= base2 + stride2_q;
        end
    end

endmodule

// File: rtl/gemm_tile_sched.sv
// Layer-level tile scheduler for the GEMM datapath.
// Accepts one layer request, then per tile: launch GEMM, wait for finish,
// drain the array, advance the BRAM bases. Watchdog and host abort end the
// layer in the error state.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   layer_start_i, num_tiles_i        layer request and tile count (0 legal)
//   mem0/1/2_stride_i                 per-tile base increments
//   abort_i                           host abort
//   gemm_finish_i                     GEMM tile-complete pulse
//   gemm_start_o                      one-cycle GEMM launch pulse
//   mem0/1/2_base_o, tile_idx_o       current tile bases and index
//   busy_o, done_o, err_o             status (err_o sticky until next layer)
// All outputs are registered; the control pulses follow the state register
// by one cycle.
module gemm_tile_sched
    import gemm_pkg::*;
#(
    parameter int TILE_W          = TILE_W_DEF,
    parameter int MEM0_ADDR_WIDTH = MEM0_AW_DEF,
    parameter int MEM1_ADDR_WIDTH = MEM1_AW_DEF,
    parameter int MEM2_ADDR_WIDTH = MEM2_AW_DEF,
    parameter int DRAIN_CYC       = DRAIN_CYC_DEF,
    parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       layer_start_i,
    input  logic [TILE_W-1:0]          num_tiles_i,
    input  logic [MEM0_ADDR_WIDTH-1:0] mem0_stride_i,
    input  logic [MEM1_ADDR_WIDTH-1:0] mem1_stride_i,
    input  logic [MEM2_ADDR_WIDTH-1:0] mem2_stride_i,
    input  logic                       abort_i,
    input  logic                       gemm_finish_i,
    output logic                       gemm_start_o,
    output logic [MEM0_ADDR_WIDTH-1:0] mem0_base_o,
    output logic [MEM1_ADDR_WIDTH-1:0] mem1_base_o,
    output logic [MEM2_ADDR_WIDTH-1:0] mem2_base_o,
    output logic [TILE_W-1:0]          tile_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int DC_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    // A zero-length drain still spends one cycle in DRAIN.
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    sched_state_e      state, state_nxt;
    logic [TILE_W-1:0] num_tiles_q;
    logic [TILE_W-1:0] tile_idx_q;
    logic [WD_W-1:0]   wd_cnt;
    logic [DC_W-1:0]   drain_cnt;
    logic              accept, last_tile, drain_last, timeout, abortable, step;

    assign accept     = (state == ST_IDLE) && layer_start_i;
    assign last_tile  = (tile_idx_q == num_tiles_q - TILE_W'(1));
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign timeout    = (wd_cnt == WD_LAST);
    assign abortable  = (state == ST_LAUNCH) || (state == ST_RUN) || (state == ST_DRAIN);
    // Abort suppresses the end-of-drain advance so bases freeze on the failed tile.
    assign step       = (state == ST_DRAIN) && drain_last && !last_tile && !abort_i;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (layer_start_i) state_nxt = (num_tiles_i == '0) ? ST_DONE : ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_RUN;
            ST_RUN: begin
                // Finish is tested first so a same-cycle timeout loses.
                if (gemm_finish_i)  state_nxt = ST_DRAIN;
                else if (timeout)   state_nxt = ST_ERR;
            end
            ST_DRAIN:  if (drain_last) state_nxt = last_tile ? ST_DONE : ST_LAUNCH;
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERR:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_i && abortable) state_nxt = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            wd_cnt      <= '0;
            drain_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            wd_cnt    <= (state == ST_RUN) ? wd_cnt + WD_W'(1) : '0;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DC_W'(1) : '0;
            if (accept) begin
                num_tiles_q <= num_tiles_i;
                tile_idx_q  <= '0;
            end else if (step) begin
                tile_idx_q  <= tile_idx_q + TILE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gemm_start_o <= 1'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            gemm_start_o <= (state == ST_LAUNCH);
            done_o       <= (state == ST_DONE) || (state == ST_ERR);
            busy_o       <= (state != ST_IDLE);
            if (state == ST_ERR) err_o <= 1'b1;
            else if (accept)     err_o <= 1'b0;
        end
    end

    assign tile_idx_o = tile_idx_q;

    gemm_base_gen #(
        .A0_W(MEM0_ADDR_WIDTH),
        .A1_W(MEM1_ADDR_WIDTH),
        .A2_W(MEM2_ADDR_WIDTH)
    ) u_base_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .load    (accept),
        .step    (step),
        .stride0 (mem0_stride_i),
        .stride1 (mem1_stride_i),
        .stride2 (mem2_stride_i),
        .base0   (mem0_base_o),
        .base1   (mem1_base_o),
        .base2   (mem2_base_o)
    );

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Directed bench for gemm_tile_sched. Instance a uses the production
// watchdog; instance b uses a 16-cycle watchdog. Both share all inputs
// except their layer_start.
module tb_gemm_tile_sched;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, abort, finish;
    logic [7:0]  num_tiles;
    logic [12:0] s0;
    logic [10:0] s1;
    logic [9:0]  s2;

    logic        gs_a, busy_a, done_a, err_a;
    logic [12:0] b0_a;
    logic [10:0] b1_a;
    logic [9:0]  b2_a;
    logic [7:0]  ti_a;
    logic        gs_b, busy_b, done_b, err_b;
    logic [12:0] b0_b;
    logic [10:0] b1_b;
    logic [9:0]  b2_b;
    logic [7:0]  ti_b;

    always #5 clk = ~clk;

    gemm_tile_sched #(.DRAIN_CYC(4), .TIMEOUT_CYC(65535)) u_dut_a (
        .clk(clk), .rst(rst), .layer_start_i(start_a), .num_tiles_i(num_tiles),
        .mem0_stride_i(s0), .mem1_stride_i(s1), .mem2_stride_i(s2),
        .abort_i(abort), .gemm_finish_i(finish), .gemm_start_o(gs_a),
        .mem0_base_o(b0_a), .mem1_base_o(b1_a), .mem2_base_o(b2_a),
        .tile_idx_o(ti_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    gemm_tile_sched #(.DRAIN_CYC(4), .TIMEOUT_CYC(16)) u_dut_b (
        .clk(clk), .rst(rst), .layer_start_i(start_b), .num_tiles_i(num_tiles),
        .mem0_stride_i(s0), .mem1_stride_i(s1), .mem2_stride_i(s2),
        .abort_i(abort), .gemm_finish_i(finish), .gemm_start_o(gs_b),
        .mem0_base_o(b0_b), .mem1_base_o(b1_b), .mem2_base_o(b2_b),
        .tile_idx_o(ti_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    int cyc = 0;
    int n_start_a = 0, n_done_a = 0, n_start_b = 0;
    int n_vec = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gs_a === 1'b1)   n_start_a <= n_start_a + 1;
        if (done_a === 1'b1) n_done_a  <= n_done_a + 1;
        if (gs_b === 1'b1)   n_start_b <= n_start_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic go_cycle(input int target);
        while (cyc < target) nxt();
    endtask

    task automatic wait_start_a(input string tag, output int c);
        int k = 0;
        @(negedge clk);
        while (gs_a !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(gs_a), 1);
        c = cyc;
    endtask

    task automatic wait_done_a(input string tag, output int c);
        int k = 0;
        @(negedge clk);
        while (done_a !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(done_a), 1);
        c = cyc;
    endtask

    // Drive a one-cycle finish d cycles after the sampled cycle.
    task automatic finish_after(input int d);
        repeat (d) @(posedge clk);
        #1 finish = 1'b1;
        nxt();
        finish = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int c[3];
        int cd, t, u, a, f, sa, da, sb;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; finish = 1'b0;
        num_tiles = '0; s0 = '0; s1 = '0; s2 = '0;
        repeat (3) nxt();
        rst = 1'b0;
        smp();
        check_eq("rst_start", 32'(gs_a), 0);
        check_eq("rst_busy", 32'(busy_a), 0);
        check_eq("rst_done", 32'(done_a), 0);
        check_eq("rst_err", 32'(err_a), 0);
        check_eq("rst_base0", 32'(b0_a), 0);
        check_eq("rst_tile", 32'(ti_a), 0);
        nxt();

        // Three tiles, finish 21 cycles after each observed start.
        sa = n_start_a; da = n_done_a;
        num_tiles = 8'd3; s0 = 13'd294; s1 = 11'd105; s2 = 10'd14;
        start_a = 1'b1; nxt(); start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_start_a("t1_start", c[i]);
            check_eq("t1_base0", 32'(b0_a), 294 * i);
            check_eq("t1_base1", 32'(b1_a), 105 * i);
            check_eq("t1_base2", 32'(b2_a), 14 * i);
            check_eq("t1_tile", 32'(ti_a), i);
            repeat (5) @(posedge clk);
            #1;
            if (i == 0) begin
                // Layer request and new parameters while busy must be ignored.
                start_a = 1'b1; num_tiles = 8'd7; s0 = 13'd1; s1 = 11'd1; s2 = 10'd1;
            end
            nxt();
            start_a = 1'b0;
            finish_after(15);
        end
        wait_done_a("t1_done", cd);
        check_eq("t1_err", 32'(err_a), 0);
        check_eq("t1_space01", c[1] - c[0], 27);
        check_eq("t1_space12", c[2] - c[1], 27);
        check_eq("t1_done_lat", cd - c[2], 27);
        nxt(); nxt();
        check_eq("t1_nstart", n_start_a - sa, 3);
        check_eq("t1_ndone", n_done_a - da, 1);

        // Zero tiles.
        sa = n_start_a;
        num_tiles = 8'd0;
        start_a = 1'b1; t = cyc; nxt(); start_a = 1'b0;
        smp();
        check_eq("t2_busy_c1", 32'(busy_a), 0);
        check_eq("t2_done_c1", 32'(done_a), 0);
        go_cycle(t + 2); smp();
        check_eq("t2_busy_c2", 32'(busy_a), 1);
        check_eq("t2_done_c2", 32'(done_a), 1);
        go_cycle(t + 3); smp();
        check_eq("t2_busy_c3", 32'(busy_a), 0);
        check_eq("t2_done_c3", 32'(done_a), 0);
        nxt();
        check_eq("t2_nstart", n_start_a - sa, 0);

        // Watchdog timeout on instance b (16 cycles).
        sb = n_start_b;
        num_tiles = 8'd2; s0 = 13'd5; s1 = 11'd6; s2 = 10'd7;
        start_b = 1'b1; t = cyc; nxt(); start_b = 1'b0;
        go_cycle(t + 18); smp();
        check_eq("t3_done_early", 32'(done_b), 0);
        check_eq("t3_err_early", 32'(err_b), 0);
        go_cycle(t + 19); smp();
        check_eq("t3_done", 32'(done_b), 1);
        check_eq("t3_err", 32'(err_b), 1);
        go_cycle(t + 20); smp();
        check_eq("t3_done_off", 32'(done_b), 0);
        check_eq("t3_busy_off", 32'(busy_b), 0);
        check_eq("t3_err_sticky", 32'(err_b), 1);
        nxt();
        check_eq("t3_nstart", n_start_b - sb, 1);

        // Next layer clears err; finish on the timeout cycle wins.
        num_tiles = 8'd1;
        start_b = 1'b1; u = cyc; nxt(); start_b = 1'b0;
        smp();
        check_eq("t3b_err_clr", 32'(err_b), 0);
        go_cycle(u + 17);
        finish = 1'b1; nxt(); finish = 1'b0;
        go_cycle(u + 19); smp();
        check_eq("t3b_done_early", 32'(done_b), 0);
        check_eq("t3b_err_early", 32'(err_b), 0);
        go_cycle(u + 23); smp();
        check_eq("t3b_done", 32'(done_b), 1);
        check_eq("t3b_err", 32'(err_b), 0);
        nxt();

        // Abort during the second tile's RUN on instance a.
        sa = n_start_a; da = n_done_a;
        num_tiles = 8'd2; s0 = 13'd294; s1 = 11'd105; s2 = 10'd14;
        start_a = 1'b1; nxt(); start_a = 1'b0;
        wait_start_a("t4_start0", c[0]);
        finish_after(5);
        wait_start_a("t4_start1", c[1]);
        check_eq("t4_space", c[1] - c[0], 11);
        a = c[1] + 3;
        go_cycle(a);
        abort = 1'b1; nxt(); abort = 1'b0;
        smp();
        check_eq("t4_done_early", 32'(done_a), 0);
        check_eq("t4_busy_early", 32'(busy_a), 1);
        go_cycle(a + 2); smp();
        check_eq("t4_done", 32'(done_a), 1);
        check_eq("t4_err", 32'(err_a), 1);
        go_cycle(a + 3); smp();
        check_eq("t4_busy_off", 32'(busy_a), 0);
        go_cycle(a + 4);
        finish = 1'b1; nxt(); finish = 1'b0;
        go_cycle(a + 10); smp();
        check_eq("t4_spur_busy", 32'(busy_a), 0);
        check_eq("t4_spur_err", 32'(err_a), 1);
        check_eq("t4_b_err", 32'(err_b), 0);
        nxt();
        check_eq("t4_nstart", n_start_a - sa, 2);
        check_eq("t4_ndone", n_done_a - da, 1);

        // Weight base wraps at 11 bits.
        num_tiles = 8'd3; s0 = 13'd10; s1 = 11'd1500; s2 = 10'd3;
        start_a = 1'b1; nxt(); start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_start_a("t5_start", c[i]);
            check_eq("t5_base0", 32'(b0_a), 10 * i);
            check_eq("t5_base1", 32'(b1_a), (i == 0) ? 0 : (i == 1) ? 1500 : 952);
            finish_after(3);
        end
        wait_done_a("t5_done", cd);
        check_eq("t5_err", 32'(err_a), 0);
        nxt();

        // Reset in the middle of the second tile's drain.
        sa = n_start_a; da = n_done_a;
        num_tiles = 8'd3; s0 = 13'd294; s1 = 11'd105; s2 = 10'd14;
        start_a = 1'b1; nxt(); start_a = 1'b0;
        wait_start_a("t6_start0", c[0]);
        finish_after(3);
        wait_start_a("t6_start1", c[1]);
        f = c[1] + 3;
        finish_after(3);
        go_cycle(f + 2);
        rst = 1'b1; nxt(); rst = 1'b0;
        smp();
        check_eq("t6_busy", 32'(busy_a), 0);
        check_eq("t6_base0", 32'(b0_a), 0);
        check_eq("t6_base1", 32'(b1_a), 0);
        check_eq("t6_base2", 32'(b2_a), 0);
        check_eq("t6_tile", 32'(ti_a), 0);
        check_eq("t6_done", 32'(done_a), 0);
        check_eq("t6_start", 32'(gs_a), 0);
        go_cycle(f + 15);
        check_eq("t6_nstart", n_start_a - sa, 2);
        check_eq("t6_ndone", n_done_a - da, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
